mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
Shares one combinational dadda_32bit multiplier among NUM_REQ requesters, e.g. per-core mul units or warp lanes. Uses a round-robin grant and a req/ack handshake. The winner's operands and the product are registered, and the low data_width bits of the product are returned on a shared result bus. Sits between the execute stages and the single multiplier datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..16).
data_width, 32, operand/result width; fixed to match dadda_32bit.
REQ_IDX_W, $clog2(NUM_REQ), width of the grant index.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset.
req  input  NUM_REQ  per-requester request; level, held until the matching ack.
a_flat  input  NUM_REQ*data_width  operand a of requester i at [i*data_width +: data_width].
b_flat  input  NUM_REQ*data_width  operand b, same packing.
ack  output  NUM_REQ  one-cycle pulse to the granted requester; result valid that cycle.
out  output  data_width  low data_width bits of a*b for the acked requester; holds until the next result.
grant_idx  output  REQ_IDX_W  index of the current or last granted requester.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst low, async): state=IDLE, ack=0, out=0, grant_idx=0, busy=0, priority pointer=0, latched operands=0.
- FSM states: IDLE, COMPUTE, ACK.
- IDLE, with any req bit set at the edge:
  - Pick the first set bit searching from the priority pointer upward, wrapping mod NUM_REQ.
  - Latch that requester's a/b into operand registers and set grant_idx.
  - Go to COMPUTE.
  - With no req set, stay in IDLE.
- COMPUTE:
  - The dadda_32bit instance sees only the latched operands.
  - At the edge: out <= product low bits, ack[grant_idx] <= 1, pointer <= (grant_idx+1) mod NUM_REQ, go to ACK.
- ACK:
  - ack is high for exactly this cycle; out is valid.
  - At the edge: ack <= 0, go to IDLE.
  - req is not sampled in ACK, so a requester that drops req on the cycle after ack is never re-granted.
- Latency: req sampled at edge 0 → ack and out visible after edge 1 → back in IDLE after edge 2. Maximum throughput is one mul per 3 cycles. An isolated request sees ack 2 edges after req is first sampled.
- Fairness: with all NUM_REQ requesting continuously, grants rotate 0,1,2,3,0,… and no requester waits more than NUM_REQ grants.
- Operands only need to be stable at the IDLE sampling edge. Changes after the grant do not affect the result.
- Overflow: the product is truncated to data_width bits; there is no flag or saturation.
- req of a non-granted requester that drops before grant: no effect, no ack.
- req of the granted requester that drops during COMPUTE: the transaction still completes and ack still pulses.
- Reset asserted mid-transaction: the in-flight operation is discarded and no ack is issued. The requester re-issues after reset.
- At most one ack bit is ever high.

Decomposition:
- Package mul_share_pkg:
  - typedef enum for state (IDLE, COMPUTE, ACK);
  - NUM_REQ default;
  - data_width from the shared const include.
- Natural sub-module: rr_pick, a combinational round-robin first-one finder.
  - Inputs: req vector and pointer.
  - Outputs: found flag and index.
  - Reusable by other shared-unit arbiters.
- dadda_32bit is instantiated as-is.

Test Plan:
- Single requester: req[2]=1, a=3, b=5 → ack[2] pulses exactly one cycle, 2 edges after req sampled; out=15; grant_idx=2; busy high for 2 cycles.
- Simultaneous requests: req=4'b1111 with operands (15,4), (15,0), (1254424,124), (7,9) from pointer 0; each requester drops req after its ack.
  - acks occur in order 0,1,2,3;
  - outs are 60, 0, 155548576, 63.
- Fairness under continuous load: req[0] and req[3] held, re-asserted immediately after each ack → grants alternate 0,3,0,3; never two consecutive grants to the same index.
- Truncation: a=32'hFFFF_FFFF, b=2 → out=32'hFFFF_FFFE.
- Operand change after grant: a changes from 3 to 100 in the COMPUTE cycle → out=15, not 500.
- Reset mid-operation: rst low during COMPUTE → ack never pulses, out=0, busy=0. After release, re-issued req (6,7) → out=42.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package mul_share_pkg;

    localparam int NUM_REQ_DEFAULT = 4;
    localparam int DATA_WIDTH      = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        ACK     = 2'd2
    } state_t;

endpackage

// File: rtl/dadda_32bit.sv
// Combinational 32x32 unsigned multiplier producing a full 64-bit product.
module dadda_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] y
);

    assign y = {32'b0, a} * {32'b0, b};

endmodule

// File: rtl/mul_share_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: searches req upward from ptr, wrapping.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    function automatic int wrap_idx(input logic [W-1:0] base, input int off);
        return (int'(base) + off) % N;
    endfunction

    // Walk offsets from farthest to nearest so the closest set bit to ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[wrap_idx(ptr, i)]) begin
                found = 1'b1;
                idx   = W'(wrap_idx(ptr, i));
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one dadda_32bit multiplier among NUM_REQ requesters
// with a req/ack handshake; one multiply per three cycles at most.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEFAULT,
    parameter int data_width = DATA_WIDTH,
    parameter int REQ_IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*data_width-1:0] a_flat,
    input  logic [NUM_REQ*data_width-1:0] b_flat,
    output logic [NUM_REQ-1:0]            ack,
    output logic [data_width-1:0]         out,
    output logic [REQ_IDX_W-1:0]          grant_idx,
    output logic                          busy
);

    state_t                 state;
    state_t                 next_state;
    logic [REQ_IDX_W-1:0]   ptr;
    logic [REQ_IDX_W-1:0]   next_ptr;
    logic [data_width-1:0]  op_a;
    logic [data_width-1:0]  op_b;
    logic                   pick_found;
    logic [REQ_IDX_W-1:0]   pick_idx;
    logic [63:0]            prod;
    logic                   unused_prod_hi;

    rr_pick #(
        .N(NUM_REQ),
        .W(REQ_IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // The multiplier only ever sees the latched operands, so requesters may
    // change their inputs freely once granted.
    dadda_32bit u_mul (
        .a (op_a),
        .b (op_b),
        .y (prod)
    );

    assign unused_prod_hi = ^prod[63:data_width];
    assign busy           = (state != IDLE);
    assign next_ptr       = (grant_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_found) next_state = COMPUTE;
            COMPUTE: next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ack defaults low every cycle so it can only ever be a single-cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack       <= '0;
            out       <= '0;
            grant_idx <= '0;
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        op_a      <= a_flat[int'(pick_idx) * data_width +: data_width];
                        op_b      <= b_flat[int'(pick_idx) * data_width +: data_width];
                        grant_idx <= pick_idx;
                    end
                end
                COMPUTE: begin
                    out <= prod[data_width-1:0];
                    ack <= NUM_REQ'(1) << grant_idx;
                    ptr <= next_ptr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter with hand-computed expectations.
module tb_mul_share_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] a_flat;
    logic [N*DW-1:0] b_flat;
    logic [N-1:0]    ack;
    logic [DW-1:0]   out;
    logic [1:0]      grant_idx;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;

    mul_share_arbiter #(.NUM_REQ(N), .data_width(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .ack       (ack),
        .out       (out),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        a_flat[i*DW +: DW] = a;
        b_flat[i*DW +: DW] = b;
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Advances until an ack appears (sampled 1 time unit after each edge) or the budget expires.
    task automatic wait_ack(input int budget, output logic [N-1:0] seen, output bit timed_out);
        timed_out = 1'b1;
        seen      = '0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (ack != '0) begin
                seen      = ack;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({ack, out, grant_idx, busy} !== '0)
            $display("[TB] FAIL reset_state got ack=%b out=%0d grant=%0d busy=%b expected all zero",
                     ack, out, grant_idx, busy);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_single();
        set_op(2, 32'd3, 32'd5);
        req = 4'b0100;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || ack !== 4'b0000 || grant_idx !== 2'd2)
            $display("[TB] FAIL single_compute got busy=%b ack=%b grant=%0d expected busy=1 ack=0000 grant=2",
                     busy, ack, grant_idx);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (ack !== 4'b0100 || out !== 32'd15 || busy !== 1'b1)
            $display("[TB] FAIL single_ack got ack=%b out=%0d busy=%b expected ack=0100 out=15 busy=1",
                     ack, out, busy);
        else n_pass++;
        req = '0;
        @(posedge clk);
        #1;
        n_checks++;
        if (ack !== 4'b0000 || busy !== 1'b0 || out !== 32'd15)
            $display("[TB] FAIL single_idle got ack=%b busy=%b out=%0d expected ack=0000 busy=0 out=15",
                     ack, busy, out);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic [N-1:0]  seen;
        bit            to;
        logic [31:0]   exp_out [4];
        exp_out = '{32'd60, 32'd0, 32'd155548576, 32'd63};
        do_reset();
        set_op(0, 32'd15, 32'd4);
        set_op(1, 32'd15, 32'd0);
        set_op(2, 32'd1254424, 32'd124);
        set_op(3, 32'd7, 32'd9);
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_ack(8, seen, to);
            n_checks++;
            if (to || seen !== (4'b0001 << k) || out !== exp_out[k])
                $display("[TB] FAIL simultaneous_%0d got ack=%b out=%0d timeout=%0d expected ack=%b out=%0d",
                         k, seen, out, to, 4'b0001 << k, exp_out[k]);
            else n_pass++;
            req = req & ~seen;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_fairness();
        logic [N-1:0] seen;
        bit           to;
        logic [N-1:0] exp_ack [4];
        exp_ack = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
        do_reset();
        set_op(0, 32'd2, 32'd3);
        set_op(3, 32'd4, 32'd5);
        req = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            wait_ack(8, seen, to);
            n_checks++;
            if (to || seen !== exp_ack[k] || out !== ((k % 2 == 0) ? 32'd6 : 32'd20))
                $display("[TB] FAIL fairness_%0d got ack=%b out=%0d timeout=%0d expected ack=%b out=%0d",
                         k, seen, out, to, exp_ack[k], (k % 2 == 0) ? 6 : 20);
            else n_pass++;
        end
        req = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_truncation();
        logic [N-1:0] seen;
        bit           to;
        set_op(1, 32'hFFFF_FFFF, 32'd2);
        req = 4'b0010;
        wait_ack(8, seen, to);
        n_checks++;
        if (to || seen !== 4'b0010 || out !== 32'hFFFF_FFFE)
            $display("[TB] FAIL truncation got ack=%b out=%h timeout=%0d expected ack=0010 out=fffffffe",
                     seen, out, to);
        else n_pass++;
        req = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_operand_change();
        logic [N-1:0] seen;
        bit           to;
        set_op(0, 32'd3, 32'd5);
        req = 4'b0001;
        @(posedge clk);
        #1;
        set_op(0, 32'd100, 32'd5);
        wait_ack(8, seen, to);
        n_checks++;
        if (to || seen !== 4'b0001 || out !== 32'd15)
            $display("[TB] FAIL operand_change got ack=%b out=%0d timeout=%0d expected ack=0001 out=15",
                     seen, out, to);
        else n_pass++;
        req = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] seen;
        logic [N-1:0] any_ack;
        bit           to;
        set_op(1, 32'd9, 32'd9);
        req = 4'b0010;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || grant_idx !== 2'd1)
            $display("[TB] FAIL reset_mid_granted got busy=%b grant=%0d expected busy=1 grant=1",
                     busy, grant_idx);
        else n_pass++;
        rst = 1'b0;
        req = '0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || out !== 32'd0 || ack !== 4'b0000 || grant_idx !== 2'd0)
            $display("[TB] FAIL reset_mid_clear got busy=%b out=%0d ack=%b grant=%0d expected 0/0/0000/0",
                     busy, out, ack, grant_idx);
        else n_pass++;
        any_ack = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            any_ack = any_ack | ack;
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            any_ack = any_ack | ack;
        end
        n_checks++;
        if (any_ack !== 4'b0000 || busy !== 1'b0)
            $display("[TB] FAIL reset_mid_no_ack got ack_seen=%b busy=%b expected ack_seen=0000 busy=0",
                     any_ack, busy);
        else n_pass++;
        set_op(1, 32'd6, 32'd7);
        req = 4'b0010;
        wait_ack(8, seen, to);
        n_checks++;
        if (to || seen !== 4'b0010 || out !== 32'd42)
            $display("[TB] FAIL reset_mid_reissue got ack=%b out=%0d timeout=%0d expected ack=0010 out=42",
                     seen, out, to);
        else n_pass++;
        req = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b0;
        req    = '0;
        a_flat = '0;
        b_flat = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_truncation();
        test_operand_change();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
